// File: rtl/pong_field.sv
// Pong game engine plus pixel generator: paddles, ball physics, scoring FSM, registered RGB.
// Define PONG_SPEEDUP_EN to make every paddle hit add 1 to ball speed (saturating at 2*BALL_SPEED).
module pong_field #(
    parameter int ACTIVE_COLS  = 640,
    parameter int ACTIVE_ROWS  = 480,
    parameter int CNT_W        = 10,
    parameter int BORDER       = 4,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_X_OFF = 16,
    parameter int PADDLE_SPEED = 4,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int HOLD_FRAMES  = 60,
    parameter int SCORE_MAX    = 9,
    parameter int COLOR_BITS   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_tick,
    input  logic [CNT_W-1:0]        row,
    input  logic [CNT_W-1:0]        col,
    input  logic                    p1_up,
    input  logic                    p1_down,
    input  logic                    p2_up,
    input  logic                    p2_down,
    input  logic                    serve,
    output logic [3*COLOR_BITS-1:0] rgb,
    output logic [3:0]              p1_score,
    output logic [3:0]              p2_score,
    output logic                    game_over
);
    localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    // One spare bit so sums like y + speed + size never wrap.
    typedef logic [CNT_W:0] pos_t;
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_POINT, S_OVER} state_t;

    localparam pos_t COLS   = pos_t'(ACTIVE_COLS);
    localparam pos_t ROWS   = pos_t'(ACTIVE_ROWS);
    localparam pos_t BRD    = pos_t'(BORDER);
    localparam pos_t PH     = pos_t'(PADDLE_H);
    localparam pos_t PSPD   = pos_t'(PADDLE_SPEED);
    localparam pos_t BSZ    = pos_t'(BALL_SIZE);
    localparam pos_t BSPD   = pos_t'(BALL_SPEED);
    localparam pos_t P1_L   = pos_t'(PADDLE_X_OFF);
    localparam pos_t P1_R   = pos_t'(PADDLE_X_OFF + PADDLE_W);
    localparam pos_t P2_L   = pos_t'(ACTIVE_COLS - PADDLE_X_OFF - PADDLE_W);
    localparam pos_t P2_R   = pos_t'(ACTIVE_COLS - PADDLE_X_OFF);
    localparam pos_t BY_MAX = pos_t'(ACTIVE_ROWS - BORDER - BALL_SIZE);
    localparam pos_t PY_MAX = pos_t'(ACTIVE_ROWS - BORDER - PADDLE_H);
    localparam pos_t BX0    = pos_t'((ACTIVE_COLS - BALL_SIZE) / 2);
    localparam pos_t BY0    = pos_t'((ACTIVE_ROWS - BALL_SIZE) / 2);
    localparam pos_t PY0    = pos_t'((ACTIVE_ROWS - PADDLE_H) / 2);

    localparam logic [3*COLOR_BITS-1:0] C_RED   = {{COLOR_BITS{1'b1}}, {2*COLOR_BITS{1'b0}}};
    localparam logic [3*COLOR_BITS-1:0] C_GREEN = {{COLOR_BITS{1'b0}}, {COLOR_BITS{1'b1}}, {COLOR_BITS{1'b0}}};
    localparam logic [3*COLOR_BITS-1:0] C_BLUE  = {{2*COLOR_BITS{1'b0}}, {COLOR_BITS{1'b1}}};

    state_t                  state_q, state_d;
    pos_t                    bx_q, bx_d, by_q, by_d, p1y_q, p1y_d, p2y_q, p2y_d, spd_q, spd_d;
    logic                    dx_q, dx_d, dy_q, dy_d;          // 1 = right / down
    logic                    serve_left_q, serve_left_d;      // p1 lost the last point
    logic [3:0]              p1s_q, p1s_d, p2s_q, p2s_d;
    logic [HW-1:0]           hold_q, hold_d;
    logic                    game_over_q, game_over_d;
    logic [3*COLOR_BITS-1:0] rgb_q, rgb_d;

    function automatic pos_t paddle_step(pos_t p, logic up, logic dn);
        pos_t n;
        n = p;
        if (up && !dn)      n = (p < BRD + PSPD) ? BRD : p - PSPD;
        else if (dn && !up) n = (p + PSPD > PY_MAX) ? PY_MAX : p + PSPD;
        return n;
    endfunction

    function automatic logic rows_overlap(pos_t y, pos_t py);
        return (y + BSZ > py) && (y < py + PH);
    endfunction

    function automatic pos_t bump(pos_t s);
`ifdef PONG_SPEEDUP_EN
        return (s < pos_t'(2 * BALL_SPEED)) ? s + pos_t'(1) : s;
`else
        return s;
`endif
    endfunction

    always_comb begin
        state_d      = state_q;
        bx_d         = bx_q;
        by_d         = by_q;
        p1y_d        = p1y_q;
        p2y_d        = p2y_q;
        spd_d        = spd_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        serve_left_d = serve_left_q;
        p1s_d        = p1s_q;
        p2s_d        = p2s_q;
        hold_d       = hold_q;
        if (frame_tick) begin
            if (state_q != S_OVER) begin
                p1y_d = paddle_step(p1y_q, p1_up, p1_down);
                p2y_d = paddle_step(p2y_q, p2_up, p2_down);
            end
            case (state_q)
                S_IDLE: if (serve) begin
                    state_d = S_PLAY;
                    dx_d    = !serve_left_q;
                end
                S_PLAY: begin
                    if (dy_q) begin
                        if (by_q + spd_q + BSZ > ROWS - BRD) begin by_d = BY_MAX; dy_d = 1'b0; end
                        else by_d = by_q + spd_q;
                    end else begin
                        if (by_q < BRD + spd_q) begin by_d = BRD; dy_d = 1'b1; end
                        else by_d = by_q - spd_q;
                    end
                    // Paddle overlap uses the wall-corrected y and this frame's paddle tops.
                    if (!dx_q) begin
                        if (bx_q >= P1_R && bx_q < P1_R + spd_q && rows_overlap(by_d, p1y_q)) begin
                            bx_d = P1_R; dx_d = 1'b1; spd_d = bump(spd_q);
                        end else if (bx_q < spd_q) begin
                            p2s_d = p2s_q + 4'd1; serve_left_d = 1'b1;
                            state_d = S_POINT; hold_d = '0;
                        end else bx_d = bx_q - spd_q;
                    end else begin
                        if (bx_q + BSZ <= P2_L && bx_q + spd_q + BSZ > P2_L && rows_overlap(by_d, p2y_q)) begin
                            bx_d = P2_L - BSZ; dx_d = 1'b0; spd_d = bump(spd_q);
                        end else if (bx_q + spd_q + BSZ > COLS) begin
                            p1s_d = p1s_q + 4'd1; serve_left_d = 1'b0;
                            state_d = S_POINT; hold_d = '0;
                        end else bx_d = bx_q + spd_q;
                    end
                end
                S_POINT: begin
                    if (hold_q == HW'(HOLD_FRAMES - 1)) begin
                        spd_d = BSPD;
                        if (p1s_q == 4'(SCORE_MAX) || p2s_q == 4'(SCORE_MAX)) state_d = S_OVER;
                        else begin state_d = S_IDLE; bx_d = BX0; by_d = BY0; end
                    end else hold_d = hold_q + 1'b1;
                end
                default: if (serve) begin
                    state_d = S_IDLE;
                    p1s_d = '0; p2s_d = '0;
                    bx_d = BX0; by_d = BY0; p1y_d = PY0; p2y_d = PY0;
                end
            endcase
        end
        game_over_d = (state_d == S_OVER);
    end

    always_comb begin
        pos_t r, c;
        r     = {1'b0, row};
        c     = {1'b0, col};
        rgb_d = '0;
        if (r < ROWS && c < COLS) begin
            if (c >= bx_q && c < bx_q + BSZ && r >= by_q && r < by_q + BSZ) rgb_d = '1;
            else if (c >= P1_L && c < P1_R && r >= p1y_q && r < p1y_q + PH) rgb_d = C_RED;
            else if (c >= P2_L && c < P2_R && r >= p2y_q && r < p2y_q + PH) rgb_d = C_BLUE;
            else if (r < BRD || r >= ROWS - BRD) rgb_d = C_GREEN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bx_q         <= BX0;
            by_q         <= BY0;
            p1y_q        <= PY0;
            p2y_q        <= PY0;
            spd_q        <= BSPD;
            dx_q         <= 1'b1;
            dy_q         <= 1'b1;
            serve_left_q <= 1'b0;
            p1s_q        <= '0;
            p2s_q        <= '0;
            hold_q       <= '0;
            game_over_q  <= 1'b0;
            rgb_q        <= '0;
        end else begin
            state_q      <= state_d;
            bx_q         <= bx_d;
            by_q         <= by_d;
            p1y_q        <= p1y_d;
            p2y_q        <= p2y_d;
            spd_q        <= spd_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            serve_left_q <= serve_left_d;
            p1s_q        <= p1s_d;
            p2s_q        <= p2s_d;
            hold_q       <= hold_d;
            game_over_q  <= game_over_d;
            rgb_q        <= rgb_d;
        end
    end

    assign rgb       = rgb_q;
    assign p1_score  = p1s_q;
    assign p2_score  = p2s_q;
    assign game_over = game_over_q;
endmodule

// File: doc/pong_field.md
# pong_field

Parametrised game engine and pixel generator for the VGA pong design. It replaces the fixed ball/paddle/border composition with one block that holds:
- both paddle positions;
- ball position, direction and speed, with wall and paddle collisions;
- per-player scoring and a serve/point/game-over state machine.

It sits after the sync pulse generator: it consumes the active row/column and a once-per-frame tick, and produces a registered RGB pixel of configurable colour depth.

## Interface
Parameters:
- ACTIVE_COLS, 640, visible columns
- ACTIVE_ROWS, 480, visible rows
- CNT_W, 10, width of row/col/position values
- BORDER, 4, height of top and bottom wall bands in rows
- PADDLE_H, 64, paddle height in rows
- PADDLE_W, 8, paddle width in columns
- PADDLE_X_OFF, 16, gap between screen edge and the outer side of each paddle
- PADDLE_SPEED, 4, rows moved per frame while a key is held
- BALL_SIZE, 8, ball side in pixels
- BALL_SPEED, 2, initial pixels per frame on each axis
- HOLD_FRAMES, 60, frames spent in POINT
- SCORE_MAX, 9, score that ends the game
- COLOR_BITS, 4, bits per colour channel

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse at start of vertical blanking
- row  in  CNT_W  current row from sync generator
- col  in  CNT_W  current column from sync generator
- p1_up, p1_down, p2_up, p2_down  in  1 each  active-high player keys, already synchronised
- serve  in  1  active-high serve/restart request
- rgb  out  3*COLOR_BITS  {R,G,B} pixel; 0 outside the active area
- p1_score, p2_score  out  4 each  current scores
- game_over  out  1  high in state OVER

## Operation
- State machine: IDLE, PLAY, POINT, OVER. All state and position updates happen only in a cycle with frame_tick=1.
- Reset values:
  - state = IDLE; scores = 0; game_over = 0; rgb = 0.
  - Ball top-left = ((ACTIVE_COLS-BALL_SIZE)/2, (ACTIVE_ROWS-BALL_SIZE)/2); dx = right, dy = down; speed = BALL_SPEED.
  - Both paddle tops = (ACTIVE_ROWS-PADDLE_H)/2.
- Paddles move in every state except OVER:
  - up alone subtracts PADDLE_SPEED; down alone adds it; up and down together means no move.
  - The top is clamped to [BORDER, ACTIVE_ROWS-BORDER-PADDLE_H].
- IDLE:
  - Ball is held at centre.
  - serve at a tick moves to PLAY, with dx toward the player who lost the last point (right after reset).
- PLAY: per tick, compute next = pos ± speed, then apply these checks in order.
  1. Wall: if next y < BORDER, set y = BORDER and dy = down. If next y + BALL_SIZE > ACTIVE_ROWS-BORDER, set y = ACTIVE_ROWS-BORDER-BALL_SIZE and dy = up.
  2. Paddle hit, left side: the ball is moving left, the current x ≥ PADDLE_X_OFF+PADDLE_W, next x < PADDLE_X_OFF+PADDLE_W, and rows overlap (by+BALL_SIZE > py and by < py+PADDLE_H). Then set x = PADDLE_X_OFF+PADDLE_W and dx = right. The right paddle is mirrored.
  3. Miss: if next x < 0 (underflow, checked as x < speed), p2 scores. If next x + BALL_SIZE > ACTIVE_COLS, p1 scores. Then go to POINT and clear the hold counter.
- POINT:
  - Ball is frozen.
  - After HOLD_FRAMES ticks, go to OVER if either score equals SCORE_MAX; otherwise go to IDLE with ball re-centred and speed = BALL_SPEED.
- OVER:
  - game_over = 1.
  - serve at a tick clears scores, re-centres ball and paddles, and goes to IDLE.
- Pixel priority: ball (white, all ones) > paddle 1 (red) > paddle 2 (blue) > wall bands (green) > black.
- Reset mid-frame returns everything to reset values immediately.

## Timing
- rgb is registered: it reflects the row/col sampled in the previous cycle (1-cycle latency).
- Positions update on the clk edge of the frame_tick cycle. Pixels drawn during blanking are not affected.
- Scores change in the same tick as the PLAY→POINT transition.
- serve is ignored in PLAY and POINT, and ignored without frame_tick.

## Configuration
- PONG_SPEEDUP_EN defined:
  - Each paddle hit increments speed by 1, saturating at 2*BALL_SPEED.
  - Speed resets to BALL_SPEED on leaving POINT and on reset.
- Not defined: speed stays constant at BALL_SPEED.

## Test plan
- Reset, then tick with p1_up held 100 frames → p1 paddle top clamps at 4; ball stays at (316,236); state IDLE.
- serve at a tick, paddle 2 parked at top → ball moves +2/+2 per frame; first bottom bounce leaves y = 468 with dy = up.
- Paddle 1 aligned with the ball moving left → x snaps to 24 and dx = right; p2_score unchanged.
- Paddle 1 moved away → p2_score goes 0→1 on the miss tick; ball frozen for 60 ticks; then IDLE, and the next serve goes left.
- Drive the score to 9 → after the hold, game_over = 1; a serve tick clears both scores and returns to IDLE.
- row=0, col=0 presented → one cycle later rgb = 12'h0F0 (wall); with PONG_SPEEDUP_EN, three paddle hits give speed 4 (saturated).
